// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory port bundle for mem_port_arbiter.
// master is the arbiter's view; slave is the core/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        bus_err;
  logic        stall;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output if_valid, if_rdata, d_valid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err, stall
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  if_valid, if_rdata, d_valid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single gnt/rvalid memory port.
// One transaction in flight; data has priority, bounded by a fetch anti-starvation streak.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] StreakMax = SW'(MAX_D_STREAK);
  localparam logic [CW-1:0] WaitLast  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 1: data port owns the transaction
  logic [SW-1:0] streak_q, streak_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          fetch_win;
  logic          rsp_ok;
  logic          rsp_to;
  logic [31:0]   rsp_data;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    fetch_win  = 1'b0;
    rsp_ok     = 1'b0;
    rsp_to     = 1'b0;
    rsp_data   = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.if_req || bus.d_req) begin
          fetch_win = bus.if_req && (!bus.d_req || (streak_q == StreakMax));
          err_d     = 1'b0;
          state_d   = StIssue;
          if (fetch_win) begin
            owner_d  = 1'b0;
            we_d     = 1'b0;
            be_d     = 4'hF;
            addr_d   = bus.if_addr;
            wdata_d  = '0;
            streak_d = '0;
          end else begin
            owner_d = 1'b1;
            we_d    = bus.d_we;
            be_d    = bus.d_be;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            // Only a data grant that overtook a waiting fetch counts toward the streak
            if (!bus.if_req) begin
              streak_d = '0;
            end else if (streak_q != StreakMax) begin
              streak_d = streak_q + 1'b1;
            end
          end
        end
      end
      StIssue: begin
        if (bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            rsp_ok  = 1'b1;
            state_d = StResp;
          end else begin
            wait_cnt_d = '0;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          rsp_ok  = 1'b1;
          state_d = StResp;
        end else if (wait_cnt_q == WaitLast) begin
          rsp_to  = 1'b1;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Writes never touch rdata; a timed-out read returns zero
    if ((rsp_ok || rsp_to) && !we_q) begin
      rsp_data = rsp_ok ? bus.mem_rdata : '0;
      if (owner_q) begin
        d_rdata_d = rsp_data;
      end else begin
        if_rdata_d = rsp_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      streak_q   <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_req   = (state_q == StIssue);
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_valid  = (state_q == StResp) && !owner_q;
  assign bus.d_valid   = (state_q == StResp) && owner_q;
  assign bus.bus_err   = (state_q == StResp) && err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall     = (bus.if_req && !bus.if_valid) || (bus.d_req && !bus.d_valid);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4, giving the consecutive data grants allowed while a fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 64, giving the WAIT cycles allowed before a bus error.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have fetch-port ports:
- if_req in 1; if_addr in 32.
- if_valid out 1: one-cycle completion pulse.
- if_rdata out 32.
REQ-006 SHALL have data-port ports:
- d_req in 1; d_we in 1; d_be in 4; d_addr in 32; d_wdata in 32.
- d_valid out 1; d_rdata out 32.
REQ-007 SHALL have memory-port ports:
- mem_req out 1; mem_we out 1; mem_be out 4; mem_addr out 32; mem_wdata out 32.
- mem_gnt in 1: request accepted.
- mem_rvalid in 1: read data or write ack.
- mem_rdata in 32.
REQ-008 SHALL have port bus_err, output, 1 bit: pulses with a timed-out completion.
REQ-009 SHALL have port stall, output, 1 bit: core hold request.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-011 IDLE: if any req is high, SHALL select an owner, latch its addr/we/be/wdata (fetch: we=0, be=4'hF, wdata=0), and go to ISSUE next cycle.
REQ-012 Selection SHALL give data priority over fetch, except when streak==MAX_D_STREAK with if_req high; fetch then wins.
REQ-013 The streak counter SHALL increment on each data grant made while if_req is high, clear on any fetch grant, clear on a data grant with if_req low, and saturate at MAX_D_STREAK.
REQ-014 ISSUE: SHALL drive mem_req=1 with latched fields stable until mem_gnt=1.
REQ-015 ISSUE with mem_gnt=1: SHALL go to RESP if mem_rvalid=1 in the same cycle, else to WAIT.
REQ-016 WAIT: SHALL drive mem_req=0; on mem_rvalid=1 SHALL go to RESP.
REQ-017 mem_rvalid SHALL be ignored in IDLE, in RESP, and in ISSUE without mem_gnt.
REQ-018 On mem_rvalid, SHALL register mem_rdata into the owner's rdata, for reads only; a write completion leaves d_rdata unchanged.
REQ-019 RESP (one cycle): SHALL assert the owner's valid=1 and perform no arbitration, then go to IDLE; requests held high into IDLE are new requests.
REQ-020 A WAIT cycle counter SHALL start at 0 on WAIT entry.
REQ-021 If TIMEOUT cycles elapse in WAIT without mem_rvalid, SHALL go to RESP with bus_err=1, owner rdata=0 for reads, and drop any later stray mem_rvalid.
REQ-022 if_rdata/d_rdata SHALL hold between completions.
REQ-023 Requesters SHALL hold req and fields stable until their valid; the arbiter samples fields only at the grant in IDLE.
REQ-024 stall SHALL be combinational: (if_req & ~if_valid) | (d_req & ~d_valid).
REQ-025 SHALL have at most one transaction outstanding; minimum completion latency is 3 cycles (IDLE->ISSUE->RESP).

Reset
REQ-026 When reset=1 at a clock edge, SHALL go to IDLE with streak=0 and the WAIT counter=0.
REQ-027 When reset=1 at a clock edge, SHALL clear all outputs: mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_valid, d_valid, bus_err, if_rdata and d_rdata.
REQ-028 Reset in ISSUE or WAIT SHALL abandon the transaction, generate no valid, and ignore any later mem_rvalid.

Verification
REQ-029 Fetch read: if_req, if_addr=0x100; mem_gnt at once; mem_rvalid 2 cycles later with 0xDEADBEEF -> if_valid pulses 1 cycle, if_rdata=0xDEADBEEF, mem_we=0, mem_be=4'hF.
REQ-030 Simultaneous requests: if_req and d_req (write, addr 0x200, wdata 0x55, be 4'h3) high together -> data granted first (mem_we=1, mem_be=4'h3), d_valid pulses, then fetch served.
REQ-031 Starvation: d_req held high with back-to-back writes and if_req high -> after 4 data grants the 5th grant is fetch; streak then clears.
REQ-032 Zero-latency memory: mem_gnt and mem_rvalid both high in the ISSUE cycle -> valid pulses on the next cycle (3-cycle completion).
REQ-033 Timeout: read issued, mem_rvalid never returned -> after 64 WAIT cycles, d_valid=1, bus_err=1, d_rdata=0; a later stray mem_rvalid is ignored.
REQ-034 Reset mid-WAIT: reset=1 for one cycle, then mem_rvalid -> no valid pulse, state IDLE, all outputs 0.
